jk_drive_generator: RTL

JK_DRIVE_GENERATOR -- requirements
Module: jk_drive_generator

---
 rtl/jk_drive_generator_pkg.sv | 24 ++
 rtl/jk_drive_generator_if.sv | 22 ++
 rtl/jk_drive_generator_excitation.sv | 27 ++
 rtl/jk_drive_generator.sv | 88 ++++++++
 4 files changed

// File: rtl/jk_drive_generator_pkg.sv
// Shared types and constants for the JK drive generator: FSM states,
// J/K excitation codes and the error-counter ceiling.
package jk_drive_generator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  localparam jk_t JK_HOLD   = '{j: 1'b0, k: 1'b0};
  localparam jk_t JK_SET    = '{j: 1'b1, k: 1'b0};
  localparam jk_t JK_RESET  = '{j: 1'b0, k: 1'b1};
  localparam jk_t JK_TOGGLE = '{j: 1'b1, k: 1'b1};

  localparam int unsigned ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/jk_drive_generator_if.sv
// Target-bit offer handshake between a bit source (master) and the
// JK drive generator (slave).
interface jk_drive_generator_if;
  logic In_Valid;
  logic In_Bit;
  logic Toggle_Mode;
  logic In_Ready;

  modport master (
    output In_Valid,
    output In_Bit,
    output Toggle_Mode,
    input  In_Ready
  );

  modport slave (
    input  In_Valid,
    input  In_Bit,
    input  Toggle_Mode,
    output In_Ready
  );
endinterface

// File: rtl/jk_drive_generator_excitation.sv
// Combinational JK excitation table: J/K needed to move Q from q_now to
// q_next, using either set/reset or toggle encoding; don't-cares resolve to 0.
module jk_excitation
  import jk_drive_generator_pkg::*;
(
  input  logic q_now,
  input  logic q_next,
  input  logic toggle_mode,
  output logic j,
  output logic k
);

  jk_t code;

  always_comb begin
    code = JK_HOLD;
    if (q_now != q_next) begin
      if (toggle_mode) code = JK_TOGGLE;
      else if (q_next) code = JK_SET;
      else             code = JK_RESET;
    end
  end

  assign j = code.j;
  assign k = code.k;

endmodule

// File: rtl/jk_drive_generator.sv
// Drives an external JK flip-flop toward a stream of target bits, then checks
// the fed-back Q one edge later and tracks mismatches.
module jk_drive_generator
  import jk_drive_generator_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Clear,
  jk_drive_generator_if.slave  bus,
  input  logic                 Q_Fb,
  output logic                 J,
  output logic                 K,
  output logic                 Q_Exp,
  output logic                 Bit_Done,
  output logic                 Mismatch,
  output logic                 Error,
  output logic [ERR_W-1:0]     Err_Count
);

  state_t state;
  logic   target;
  logic   exc_j;
  logic   exc_k;
  logic   accept;

  // Excitation is evaluated on the live inputs at accept, so J/K are already
  // registered when DRIVE begins; Toggle_Mode needs no separate latch.
  jk_excitation u_excitation (
    .q_now       (Q_Exp),
    .q_next      (bus.In_Bit),
    .toggle_mode (bus.Toggle_Mode),
    .j           (exc_j),
    .k           (exc_k)
  );

  assign bus.In_Ready = (state == IDLE) && !Clear;
  assign accept       = bus.In_Valid && bus.In_Ready;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state     <= IDLE;
      target    <= 1'b0;
      J         <= 1'b0;
      K         <= 1'b0;
      Q_Exp     <= 1'b0;
      Bit_Done  <= 1'b0;
      Mismatch  <= 1'b0;
      Error     <= 1'b0;
      Err_Count <= '0;
    end else begin
      Bit_Done <= 1'b0;
      Mismatch <= 1'b0;
      unique case (state)
        IDLE: begin
          J <= 1'b0;
          K <= 1'b0;
          if (accept) begin
            target <= bus.In_Bit;
            J      <= exc_j;
            K      <= exc_k;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          J     <= 1'b0;
          K     <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          Bit_Done <= 1'b1;
          // Resync to the real flip-flop so the next excitation starts from truth.
          Q_Exp    <= Q_Fb;
          if (Q_Fb != target) begin
            Mismatch <= 1'b1;
            Error    <= 1'b1;
            if (Err_Count != ERR_MAX) Err_Count <= Err_Count + 8'd1;
          end
          state <= IDLE;
        end
        default: begin
          J     <= 1'b0;
          K     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
